// File: rtl/led_pwm_array.sv
// led_pwm_array: N-channel LED PWM engine with group dim/blink and fade.
// Register bus in, registered leds and readback out.
module led_pwm_array #(
  parameter int NUM_CH    = 4,
  parameter int PRESCALE  = 1,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data,
  input  logic                 w_en,
  input  logic                 r_en,
  output logic [7:0]           rdata,
  output logic [NUM_CH-1:0]    leds
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // mode_q = {sleep, dmblnk, invrt, fade_en}
  logic [3:0]              mode_q, mode_d;
  logic [7:0]              grppwm_q, grppwm_d;
  logic [7:0]              grpfreq_q, grpfreq_d;
  logic [7:0]              rate_q, rate_d;
  logic [NUM_CH-1:0][1:0]  lo_q, lo_d;
  logic [NUM_CH-1:0][7:0]  pwm_q, pwm_d;
  logic [NUM_CH-1:0][7:0]  eff_q, eff_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [7:0]              pcnt_q, pcnt_d;
  logic [7:0]              gcnt_q, gcnt_d;
  logic [7:0]              gdiv_q, gdiv_d;
  logic [7:0]              fdiv_q, fdiv_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [NUM_CH-1:0]       leds_q, leds_d;
  logic [7:0]              rv;

  logic sleep, dmblnk, invrt, fade_en;
  logic run, tick, bnd, grp_on, raw, lv;

  assign sleep   = mode_q[3];
  assign dmblnk  = mode_q[2];
  assign invrt   = mode_q[1];
  assign fade_en = mode_q[0];
  assign run     = ~sleep;
  assign tick    = (pre_q == PW'(PRESCALE - 1));
  assign bnd     = run & tick & (pcnt_q == 8'hFF);
  assign grp_on  = (gcnt_q < grppwm_q);

  // register-bus writes
  always_comb begin
    mode_d    = mode_q;
    grppwm_d  = grppwm_q;
    grpfreq_d = grpfreq_q;
    rate_d    = rate_q;
    lo_d      = lo_q;
    pwm_d     = pwm_q;
    if (w_en) begin
      if (addr == ADDR_BITS'(0))
        mode_d = {data[4], data[3], data[2], data[0]};
      if (addr == ADDR_BITS'(1)) grppwm_d = data;
      if (addr == ADDR_BITS'(2)) grpfreq_d = data;
      if (addr == ADDR_BITS'(3)) rate_d = data;
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_BITS'(4 + i / 4))
          lo_d[i] = data[2*(i%4) +: 2];
        if (addr == ADDR_BITS'(8 + i))
          pwm_d[i] = data;
      end
    end
  end

  // readback mux, sampled on r_en from pre-write state
  always_comb begin
    rv = 8'h00;
    if (addr == ADDR_BITS'(0))
      rv = {3'b000, mode_q[3:1], 1'b0, mode_q[0]};
    if (addr == ADDR_BITS'(1)) rv = grppwm_q;
    if (addr == ADDR_BITS'(2)) rv = grpfreq_q;
    if (addr == ADDR_BITS'(3)) rv = rate_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_BITS'(4 + i / 4))
        rv[2*(i%4) +: 2] = lo_q[i];
      if (addr == ADDR_BITS'(8 + i))
        rv = pwm_q[i];
    end
    rdata_d = r_en ? rv : rdata_q;
  end

  // prescaler, pwm counter and group counter
  always_comb begin
    pre_d  = pre_q;
    pcnt_d = pcnt_q;
    gcnt_d = gcnt_q;
    gdiv_d = gdiv_q;
    if (!run) begin
      pre_d  = '0;
      pcnt_d = 8'h00;
      gcnt_d = 8'h00;
      gdiv_d = 8'h00;
    end else begin
      if (tick) begin
        pre_d  = '0;
        pcnt_d = pcnt_q + 8'd1;
      end else begin
        pre_d  = pre_q + PW'(1);
      end
      if (!dmblnk) begin
        gdiv_d = 8'h00;
        if (bnd) gcnt_d = gcnt_q + 8'd1;
      end else if (bnd) begin
        if (gdiv_q == grpfreq_q) begin
          gdiv_d = 8'h00;
          gcnt_d = gcnt_q + 8'd1;
        end else begin
          gdiv_d = gdiv_q + 8'd1;
        end
      end
    end
  end

  // effective duty: snap or fade toward target at period boundaries
  always_comb begin
    eff_d  = eff_q;
    fdiv_d = fdiv_q;
    if (!run || !fade_en) begin
      fdiv_d = 8'h00;
    end else if (bnd) begin
      fdiv_d = (fdiv_q == rate_q) ? 8'h00 : fdiv_q + 8'd1;
    end
    if (bnd) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!fade_en) begin
          eff_d[i] = pwm_q[i];
        end else if (fdiv_q == rate_q) begin
          if (eff_q[i] < pwm_q[i])
            eff_d[i] = eff_q[i] + 8'd1;
          else if (eff_q[i] > pwm_q[i])
            eff_d[i] = eff_q[i] - 8'd1;
        end
      end
    end
  end

  // per-channel output select, sleep blanking and inversion
  always_comb begin
    leds_d = '0;
    raw    = 1'b0;
    lv     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw = (pcnt_q < eff_q[i]);
      lv  = 1'b0;
      unique case (1'b1)
        (lo_q[i] == 2'b00): lv = 1'b0;
        (lo_q[i] == 2'b01): lv = 1'b1;
        (lo_q[i] == 2'b10): lv = raw;
        (lo_q[i] == 2'b11): lv = raw & grp_on;
        default:            lv = 1'b0;
      endcase
      leds_d[i] = (lv & run) ^ invrt;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= '0;
      grppwm_q  <= '0;
      grpfreq_q <= '0;
      rate_q    <= '0;
      lo_q      <= '0;
      pwm_q     <= '0;
      eff_q     <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      gcnt_q    <= '0;
      gdiv_q    <= '0;
      fdiv_q    <= '0;
      rdata_q   <= '0;
      leds_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      grppwm_q  <= grppwm_d;
      grpfreq_q <= grpfreq_d;
      rate_q    <= rate_d;
      lo_q      <= lo_d;
      pwm_q     <= pwm_d;
      eff_q     <= eff_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      gcnt_q    <= gcnt_d;
      gdiv_q    <= gdiv_d;
      fdiv_q    <= fdiv_d;
      rdata_q   <= rdata_d;
      leds_q    <= leds_d;
    end
  end

  assign rdata = rdata_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_led_pwm_array.sv
// tb_led_pwm_array: directed bench for led_pwm_array.
// Per-period high counts are checked against a queue of expected duties.
module tb_led_pwm_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] addr;
  logic [7:0] data;
  logic       w_en, r_en;
  logic [7:0] rdata4, rdata10;
  logic [3:0] leds4;
  logic [9:0] leds10;

  int checks = 0;
  int fails  = 0;
  int exp_q[$];
  int wr_p = -1;
  logic [4:0] wr_a;
  logic [7:0] wr_d;

  always #5 clk = ~clk;

  led_pwm_array #(.NUM_CH(4), .PRESCALE(1), .ADDR_BITS(5)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .data(data),
    .w_en(w_en), .r_en(r_en), .rdata(rdata4), .leds(leds4)
  );

  led_pwm_array #(.NUM_CH(10), .PRESCALE(1), .ADDR_BITS(5)) dut10 (
    .clk(clk), .reset(reset), .addr(addr), .data(data),
    .w_en(w_en), .r_en(r_en), .rdata(rdata10), .leds(leds10)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    addr  = '0;
    data  = '0;
    w_en  = 1'b0;
    r_en  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data = d;
    w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk);
    addr = a;
    r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic rw(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data = d;
    w_en = 1'b1;
    r_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic push4(input int e0, input int e1,
                       input int e2, input int e3);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
  endtask

  // counts high clks per channel over 256-clk windows; -1 means skip
  task automatic measure(input int np, input string tag);
    int cnt[4];
    int e;
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        for (int c = 0; c < 4; c++) cnt[c] += int'(leds4[c]);
        if (p == wr_p && i == 0) begin
          addr = wr_a;
          data = wr_d;
          w_en = 1'b1;
        end else if (p == wr_p && i == 1) begin
          w_en = 1'b0;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          if (e >= 0)
            chk($sformatf("%s_p%0d_ch%0d", tag, p, c), cnt[c], e);
        end
      end
    end
    wr_p = -1;
  endtask

  initial begin
    int cnt;
    int first_low;
    int e;

    // reset state and LEDOUT full-on latency
    do_reset();
    chk("rst_leds", leds4, 4'h0);
    chk("rst_rdata", rdata4, 8'h00);
    wr(5'd4, 8'h55);
    chk("ledout_lag", leds4, 4'h0);
    @(negedge clk);
    chk("ledout_on4", leds4, 4'hF);
    chk("ledout_on10", leds10[3:0], 4'hF);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      chk($sformatf("rd4_a%0d", a), rdata4, (a == 4) ? 8'h55 : 8'h00);
      chk($sformatf("rd10_a%0d", a), rdata10, (a == 4) ? 8'h55 : 8'h00);
    end

    // PWM duties and a mid-period retarget
    do_reset();
    wr(5'd0, 8'h10);
    wr(5'd4, 8'hAA);
    wr(5'd8, 8'h40);
    wr(5'd9, 8'h80);
    wr(5'd10, 8'hC0);
    wr(5'd11, 8'hFF);
    wr(5'd0, 8'h00);
    push4(0, 0, 0, 0);
    push4(64, 128, 192, 255);
    push4(64, 16, 192, 255);
    wr_p = 1;
    wr_a = 5'd9;
    wr_d = 8'h10;
    measure(3, "duty");

    // group blink gating
    do_reset();
    wr(5'd0, 8'h10);
    wr(5'd4, 8'h07);
    wr(5'd8, 8'hFF);
    wr(5'd1, 8'h04);
    wr(5'd2, 8'h01);
    wr(5'd0, 8'h08);
    for (int p = 0; p < 12; p++)
      push4((p == 0) ? 0 : ((p < 8) ? 255 : 0), 256, 0, 0);
    measure(12, "blink");
    push4(-1, -1, -1, -1);
    push4(0, 256, 0, 0);
    wr_p = 0;
    wr_a = 5'd1;
    wr_d = 8'h00;
    measure(2, "grp0");
    push4(-1, -1, -1, -1);
    push4(255, 256, 0, 0);
    wr_p = 0;
    wr_a = 5'd1;
    wr_d = 8'h80;
    measure(2, "grp80");

    // sleep with invert, then restart from pcnt 0
    do_reset();
    wr(5'd0, 8'h10);
    wr(5'd4, 8'h02);
    wr(5'd8, 8'h40);
    wr(5'd0, 8'h00);
    push4(0, 0, 0, 0);
    push4(64, 0, 0, 0);
    measure(2, "pre_sleep");
    wr(5'd0, 8'h14);
    @(negedge clk);
    chk("sleep_leds", leds4, 4'hF);
    rd(5'd8);
    chk("sleep_rd_pwm0", rdata4, 8'h40);
    rd(5'd0);
    chk("sleep_rd_mode", rdata4, 8'h14);
    repeat (300) @(negedge clk);
    chk("sleep_hold", leds4, 4'hF);
    wr(5'd0, 8'h00);
    exp_q.push_back(64);
    exp_q.push_back(64);
    cnt = 0;
    first_low = -1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      cnt += int'(leds4[0]);
      if (!leds4[0] && first_low < 0) first_low = i;
    end
    e = exp_q.pop_front();
    chk("wake_count", cnt, e);
    e = exp_q.pop_front();
    chk("wake_first_low", first_low, e);

    // fade up to 0x10, then retarget down to 0x08
    do_reset();
    wr(5'd0, 8'h10);
    wr(5'd4, 8'h20);
    wr(5'd3, 8'h03);
    wr(5'd10, 8'h10);
    wr(5'd0, 8'h01);
    for (int p = 0; p < 100; p++) begin
      if (p < 68)
        e = (p / 4 > 16) ? 16 : p / 4;
      else
        e = (16 - (p - 64) / 4 < 8) ? 8 : 16 - (p - 64) / 4;
      push4(0, 0, e, 0);
    end
    wr_p = 66;
    wr_a = 5'd10;
    wr_d = 8'h08;
    measure(100, "fade");

    // 10-channel map edges and read-during-write
    do_reset();
    wr(5'd6, 8'hFF);
    rd(5'd6);
    chk("ch10_lo2", rdata10, 8'h0F);
    chk("ch4_lo2", rdata4, 8'h00);
    wr(5'd20, 8'hAB);
    rd(5'd20);
    chk("ch10_pwm12", rdata10, 8'h00);
    wr(5'd17, 8'h5A);
    rd(5'd17);
    chk("ch10_pwm9", rdata10, 8'h5A);
    chk("ch4_pwm9", rdata4, 8'h00);
    wr(5'd6, 8'h55);
    @(negedge clk);
    chk("ch10_leds", leds10, 10'h300);
    rw(5'd6, 8'h00);
    chk("rw_old", rdata10, 8'h05);
    rd(5'd6);
    chk("rw_new", rdata10, 8'h00);

    // asynchronous reset mid-fade
    do_reset();
    wr(5'd0, 8'h01);
    wr(5'd4, 8'h55);
    wr(5'd8, 8'h80);
    rd(5'd4);
    chk("pre_arst_leds", leds4, 4'hF);
    chk("pre_arst_rdata", rdata4, 8'h55);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_leds4", leds4, 4'h0);
    chk("arst_leds10", leds10, 10'h000);
    chk("arst_rdata4", rdata4, 8'h00);
    chk("arst_rdata10", rdata10, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(5'd8);
    chk("arst_pwm0", rdata4, 8'h00);
    rd(5'd0);
    chk("arst_mode", rdata4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
